// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: state encoding and channel roles shared by the SDRAM arbiter.
// Channel roles document the fixed wiring of the low channels.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int CH_LOAD = 0;
    localparam int CH_DMA  = 1;
    localparam int CH_CPU  = 2;

    // Watchdog counter width; covers the full TMO range.
    localparam int CNT_W = 16;

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner selection over NCH level requests.
// RAM_ARB_RR_EN searches from ptr with wrap; otherwise the lowest index wins.
module ram_arb_pick
    import ram_arb_pkg::*;
#(
    parameter int NCH = 3,
    parameter int IW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic           valid,
    output logic [IW-1:0]  idx
);

`ifdef RAM_ARB_RR_EN
    int pos;

    // Walk offsets downward so the smallest offset from ptr is the last write.
    always_comb begin
        valid = |req;
        idx   = '0;
        pos   = 0;
        for (int off = NCH - 1; off >= 0; off--) begin
            pos = (int'(ptr) + off) % NCH;
            if (req[pos]) begin
                idx = IW'(pos);
            end
        end
    end
`else
    logic unused_ptr;

    assign unused_ptr = ^ptr;

    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: request/ack arbiter in front of the single-port sram controller.
// Define RAM_ARB_RR_EN for round-robin selection; default is fixed priority.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NCH = 3,
    parameter int AW  = 25,
    parameter int DW  = 8,
    parameter int TMO = 255
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic [NCH-1:0]          ch_req,
    input  logic [NCH-1:0]          ch_we,
    input  logic [NCH*AW-1:0]       ch_addr,
    input  logic [NCH*DW-1:0]       ch_din,
    output logic [NCH-1:0]          ch_ack,
    output logic [NCH-1:0]          ch_err,
    output logic [DW-1:0]           rdata,
    output logic [$clog2(NCH)-1:0]  grant,
    output logic                    busy,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_din,
    output logic                    mem_we,
    output logic                    mem_rd,
    input  logic [DW-1:0]           mem_dout,
    input  logic                    mem_ready
);

    localparam int GW = $clog2(NCH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO - 1);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             lat_we;
    logic             pick_valid;
    logic [GW-1:0]    pick_idx;
    logic [GW-1:0]    ptr;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_din;
    logic [NCH-1:0]   done_vec;

    ram_arb_pick #(
        .NCH (NCH),
        .IW  (GW)
    ) u_pick (
        .req   (ch_req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign sel_we   = ch_we[pick_idx];
    assign sel_addr = ch_addr[pick_idx*AW +: AW];
    assign sel_din  = ch_din[pick_idx*DW +: DW];
    assign done_vec = NCH'(1) << grant;

`ifdef RAM_ARB_RR_EN
    // Next search starts just past the channel granted last.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (state == IDLE && pick_valid) begin
            ptr <= (pick_idx == GW'(NCH - 1)) ? '0 : pick_idx + GW'(1);
        end
    end
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_we   <= 1'b0;
            grant    <= '0;
            busy     <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_we   <= 1'b0;
            mem_rd   <= 1'b0;
            rdata    <= '0;
            ch_ack   <= '0;
            ch_err   <= '0;
        end else begin
            mem_we <= 1'b0;
            mem_rd <= 1'b0;
            ch_ack <= '0;
            ch_err <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= ISSUE;
                        busy     <= 1'b1;
                        grant    <= pick_idx;
                        lat_we   <= sel_we;
                        mem_we   <= sel_we;
                        mem_rd   <= !sel_we;
                        mem_addr <= sel_addr;
                        mem_din  <= sel_din;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (mem_ready) begin
                        if (!lat_we) begin
                            rdata <= mem_dout;
                        end
                        ch_ack <= done_vec;
                        state  <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        // Watchdog: complete with error, never retried.
                        rdata  <= '0;
                        ch_ack <= done_vec;
                        ch_err <= done_vec;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
